// File: rtl/secuencia_rtc.sv
// RTC sweep sequencer: reads 8 RTC registers into a local buffer once per frame,
// then streams them to the display interface inside a 12-cycle load window.
module secuencia_rtc #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned N_BYTES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_frame,
  input  logic       rtc_ack,
  input  logic [7:0] rtc_dato,
  output logic       rtc_rd,
  output logic [2:0] rtc_addr,
  output logic       inicioSecuencia,
  output logic [7:0] datoRTC,
  output logic       error_rtc,
  output logic       ocupado
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned K_W      = 4;
  localparam int unsigned SEND_LEN = N_BYTES + 4;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, STORE, SEND} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [K_W-1:0]   k, k_n;
  logic             flag, flag_n;
  logic             err_n, rd_n, ini_n, ocup_n;
  logic [7:0]       dato_n;
  logic             buf_we;
  logic [7:0]       buf_wdata;
  logic [7:0]       buffer [N_BYTES];

  assign rtc_addr = idx;

  // State, counters, buffer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      k               <= '0;
      flag            <= 1'b0;
      rtc_rd          <= 1'b0;
      inicioSecuencia <= 1'b0;
      datoRTC         <= 8'h00;
      error_rtc       <= 1'b0;
      ocupado         <= 1'b0;
      for (int i = 0; i < int'(N_BYTES); i++) buffer[i] <= 8'h00;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      cnt             <= cnt_n;
      k               <= k_n;
      flag            <= flag_n;
      rtc_rd          <= rd_n;
      inicioSecuencia <= ini_n;
      datoRTC         <= dato_n;
      error_rtc       <= err_n;
      ocupado         <= ocup_n;
      if (buf_we) buffer[idx] <= buf_wdata;
    end
  end

  // Next state; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    k_n       = k;
    flag_n    = flag;
    err_n     = error_rtc;
    buf_we    = 1'b0;
    buf_wdata = 8'h00;
    case (state)
      IDLE: begin
        if (tick_frame) begin
          idx_n   = '0;
          flag_n  = 1'b0;
          state_n = REQ;
        end
      end
      REQ: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = cnt + CNT_W'(1);
        // Ack wins over timeout; timeout fires on the TIMEOUT-th cycle rd is high
        if (rtc_ack) begin
          buf_we    = 1'b1;
          buf_wdata = rtc_dato;
          state_n   = STORE;
        end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
          buf_we    = 1'b1;
          flag_n    = 1'b1;
          state_n   = STORE;
        end
      end
      STORE: begin
        if (idx == IDX_W'(N_BYTES - 1)) begin
          k_n     = '0;
          err_n   = flag;
          state_n = SEND;
        end else begin
          idx_n   = idx + IDX_W'(1);
          state_n = REQ;
        end
      end
      SEND: begin
        if (k == K_W'(SEND_LEN - 1)) state_n = IDLE;
        else                         k_n     = k + K_W'(1);
      end
      default: state_n = IDLE;
    endcase

    rd_n   = (state_n == REQ) || (state_n == WAIT);
    ini_n  = (state_n == SEND);
    ocup_n = (state_n != IDLE);
    dato_n = 8'h00;
    if ((state_n == SEND) && (k_n >= K_W'(1)) && (k_n <= K_W'(N_BYTES)))
      dato_n = buffer[IDX_W'(k_n - K_W'(1))];
  end

endmodule

// File: doc/secuencia_rtc.md
SECUENCIA_RTC -- requirements
Module: secuencia_rtc

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for rtc_ack per byte.
REQ-002 SHALL have parameter N_BYTES, fixed at 8, giving the number of RTC registers swept per frame.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tick_frame  input  1  one-cycle pulse requesting a new sweep, once per display frame.
REQ-006 rtc_ack  input  1  RTC read data valid; sampled only while rtc_rd=1.
REQ-007 rtc_dato  input  8  RTC read data, valid when rtc_ack=1.
REQ-008 rtc_rd  output  1  read request to the RTC.
REQ-009 rtc_addr  output  3  RTC register address, 0..7.
REQ-010 inicioSecuencia  output  1  load window to the display interface.
REQ-011 datoRTC  output  8  byte stream to the display interface.
REQ-012 error_rtc  output  1  set when the last sweep had at least one timeout.
REQ-013 ocupado  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, WAIT, STORE and SEND.
REQ-015 IDLE: on tick_frame=1 SHALL clear the byte index to 0 and go to REQ the next cycle; otherwise stay.
REQ-016 REQ: SHALL assert rtc_rd=1 with rtc_addr=index, clear the timeout counter, and go to WAIT.
REQ-017 WAIT: SHALL hold rtc_rd=1 and rtc_addr stable and increment the timeout counter each cycle.
REQ-018 WAIT on rtc_ack=1: SHALL latch rtc_dato into buffer[index], drop rtc_rd the next cycle, and go to STORE.
REQ-019 WAIT when the counter reaches TIMEOUT with no ack: SHALL write 8'h00 to buffer[index], set the sweep-error flag, drop rtc_rd, and go to STORE.
REQ-020 If ack and timeout occur in the same cycle, ack SHALL take priority.
REQ-021 STORE: if index=7, go to SEND with the window counter at 0; otherwise increment index and go to REQ.
REQ-022 A read handshake SHALL therefore take a minimum of 3 cycles (REQ, WAIT with ack, STORE).
REQ-023 SEND SHALL last exactly 12 cycles, counted k=0..11, with inicioSecuencia=1 for all 12.
REQ-024 In SEND, datoRTC SHALL be 8'h00 at k=0, buffer[k-1] at k=1..8, and 8'h00 at k=9..11.
REQ-025 inicioSecuencia SHALL fall in the cycle after k=11, and the FSM SHALL return to IDLE.
REQ-026 error_rtc SHALL update on the cycle entering SEND, to the sweep-error flag, and hold until the next SEND.
REQ-027 tick_frame while ocupado=1 SHALL be ignored; no queuing and no restart.
REQ-028 Outside SEND, inicioSecuencia SHALL be 0 and datoRTC SHALL be 8'h00.
REQ-029 rtc_ack outside WAIT SHALL be ignored.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-031 The buffer SHALL be 8x8 registers, and bytes SHALL be emitted in address order 0..7.

Reset
REQ-032 reset=0 SHALL force asynchronously: state IDLE, index 0, counters 0, rtc_rd=0, rtc_addr=0, inicioSecuencia=0, datoRTC=8'h00, error_rtc=0, ocupado=0, buffer all 8'h00.
REQ-033 Reset asserted mid-sweep or mid-SEND SHALL abort immediately.
REQ-034 After release, no sweep SHALL start until a new tick_frame is seen.

Verification
REQ-035 Nominal sweep: tick_frame pulse; RTC model acks each rd after 1 cycle with data 24,4,3,23,12,21,5,6 -> inicioSecuencia high 12 cycles; datoRTC = 00,24,4,3,23,12,21,5,6,00,00,00; error_rtc=0.
REQ-036 Timeout: register 3 never acked, others as in REQ-035 -> rd for addr 3 held 255 cycles; stream = 00,24,4,3,00,12,21,5,6,00,00,00; error_rtc=1; a next clean sweep clears error_rtc.
REQ-037 Busy tick: second tick_frame during WAIT of addr 2 -> exactly one SEND window; no extra rd pulses after return to IDLE.
REQ-038 Ack/timeout collision: ack arrives exactly on cycle TIMEOUT -> data latched, error_rtc=0.
REQ-039 Reset mid-SEND at k=5: reset low 1 cycle -> inicioSecuencia=0 and datoRTC=00 within the reset cycle; no activity until the next tick_frame.
REQ-040 Spurious ack: rtc_ack pulses while in IDLE -> buffer and outputs unchanged.
